// File: rtl/rdata_channel_pkg.sv
// Shared constants for the macroblock read/write data channels: FSM encodings,
// beat geometry and counter widths.
package rdata_channel_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_INIT = 4'b0010,
        ST_RECV = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    // One macroblock of YUV420 source data is 384 bytes, split into 1024-bit beats
    localparam int MB_BYTES        = 384;
    localparam int RD_BEATS_PER_MB = 3;
    localparam int MB_CNT_W        = 22;
    localparam int MB_DIM_W        = 11;

    localparam int WR_BEATS_PER_MB = 3;
    localparam int WR_DATA_W       = 1024;
    localparam int WR_STRB_W       = WR_DATA_W / 8;

endpackage

// File: rtl/rdata_channel.sv
// AXI read-data sink: forwards each accepted beat straight into a downstream FIFO,
// counts beats per macroblock and flags response/rlast errors for one job.
module rdata_channel
    import rdata_channel_pkg::*;
#(
    parameter int DATA_W       = 1024,
    parameter int BEATS_PER_MB = RD_BEATS_PER_MB
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    input  logic              m_axi_rlast,
    output logic              m_axi_rready,
    input  logic              start_pulse,
    input  logic [31:0]       mb_w,
    input  logic [31:0]       mb_h,
    output logic              done_pulse,
    output logic              err_resp,
    output logic              err_last,
    input  logic              fifo_full,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_wr,
    output logic [3:0]        o_dbg_state
);

    localparam int BEAT_W = (BEATS_PER_MB > 1) ? $clog2(BEATS_PER_MB) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_MB - 1);

    state_e                r_state;
    state_e                w_next_state;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [MB_CNT_W-1:0]   r_mb_cnt;
    logic [MB_CNT_W-1:0]   r_mb_total;
    logic                  r_done;
    logic                  r_err_resp;
    logic                  r_err_last;

    logic [MB_CNT_W-1:0]   w_mb_product;
    logic                  w_rready;
    logic                  w_accept;
    logic                  w_beat_wrap;
    logic                  w_last_mb;

    // Handshake: a beat moves when m_axi_rvalid && m_axi_rready in the same cycle;
    // rready is only offered in RECV while the FIFO has room, so fifo_wr == accept.
    assign w_mb_product = MB_CNT_W'(mb_w[MB_DIM_W-1:0]) * MB_CNT_W'(mb_h[MB_DIM_W-1:0]);
    assign w_rready     = (r_state == ST_RECV) && !fifo_full;
    assign w_accept     = w_rready && m_axi_rvalid;
    assign w_beat_wrap  = (r_beat_cnt == LAST_BEAT);
    assign w_last_mb    = (MB_CNT_W'(r_mb_cnt + 1'b1) == r_mb_total);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start_pulse) w_next_state = ST_INIT;
            ST_INIT: w_next_state = (w_mb_product == '0) ? ST_DONE : ST_RECV;
            ST_RECV: if (w_accept && w_beat_wrap && w_last_mb) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        m_axi_rready = w_rready;
        fifo_wr      = w_accept;
        fifo_din     = m_axi_rdata;
        done_pulse   = r_done;
        err_resp     = r_err_resp;
        err_last     = r_err_last;
        o_dbg_state  = r_state;
    end

    // done_pulse is registered from the next state so it lines up exactly with DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (w_next_state == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_mb_cnt   <= '0;
            r_mb_total <= '0;
            r_err_resp <= 1'b0;
            r_err_last <= 1'b0;
        end else if (r_state == ST_INIT) begin
            r_beat_cnt <= '0;
            r_mb_cnt   <= '0;
            r_mb_total <= w_mb_product;
            r_err_resp <= 1'b0;
            r_err_last <= 1'b0;
        end else if (w_accept) begin
            r_beat_cnt <= w_beat_wrap ? '0 : r_beat_cnt + 1'b1;
            if (w_beat_wrap) begin
                r_mb_cnt <= r_mb_cnt + 1'b1;
            end
            // Errors are recorded only; the beat is still forwarded and counted
            if (m_axi_rresp != 2'b00) begin
                r_err_resp <= 1'b1;
            end
            if (m_axi_rlast != w_beat_wrap) begin
                r_err_last <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rdata_channel.sv
// Self-checking bench for rdata_channel: randomized beats and FIFO back-pressure
// checked cycle by cycle against a job-level model (beats expected = w*h*3).
module tb_rdata_channel;

    localparam int DATA_W = 128;
    localparam int BPM    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DATA_W-1:0] m_axi_rdata = '0;
    logic [1:0]        m_axi_rresp = 2'b00;
    logic              m_axi_rvalid = 1'b0;
    logic              m_axi_rlast = 1'b0;
    logic              m_axi_rready;
    logic              start_pulse = 1'b0;
    logic [31:0]       mb_w = '0;
    logic [31:0]       mb_h = '0;
    logic              done_pulse;
    logic              err_resp;
    logic              err_last;
    logic              fifo_full = 1'b0;
    logic [DATA_W-1:0] fifo_din;
    logic              fifo_wr;
    logic [3:0]        o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    rdata_channel #(
        .DATA_W       (DATA_W),
        .BEATS_PER_MB (BPM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rlast  (m_axi_rlast),
        .m_axi_rready (m_axi_rready),
        .start_pulse  (start_pulse),
        .mb_w         (mb_w),
        .mb_h         (mb_h),
        .done_pulse   (done_pulse),
        .err_resp     (err_resp),
        .err_last     (err_last),
        .fifo_full    (fifo_full),
        .fifo_din     (fifo_din),
        .fifo_wr      (fifo_wr),
        .o_dbg_state  (o_dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        d = '0;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // One job end to end. Inputs are driven at the falling edge, outputs checked #1 later.
    task automatic run_job(input int w, input int h, input int full_pct, input int vld_pct,
                           input int hold_at, input int hold_len, input bit toggle,
                           input int bad_resp_beat, input int bad_last_beat,
                           input int stray_at, input string name);
        int  total;
        int  b;
        int  c;
        int  max_c;
        bit  full;
        bit  vld;
        bit  exp_acc;
        bit  exp_er;
        bit  exp_el;
        bit  rl;
        bit  on_boundary;
        logic [1:0] rr;
        logic [DATA_W-1:0] got;
        total  = (w & 2047) * (h & 2047) * BPM;
        max_c  = total * 20 + 100;
        exp_er = 1'b0;
        exp_el = 1'b0;
        exp_q.delete();
        for (int i = 0; i < total; i++) exp_q.push_back(rand_data());

        @(negedge clk);
        start_pulse = 1'b1; mb_w = w; mb_h = h;
        m_axi_rvalid = 1'b1; fifo_full = 1'b0; m_axi_rdata = rand_data();
        #1;
        n_checks++;
        if (m_axi_rready !== 1'b0 || fifo_wr !== 1'b0 || done_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start cycle: rready=%b wr=%b done=%b required 0 0 0", name, m_axi_rready, fifo_wr, done_pulse);
        end
        @(negedge clk);
        start_pulse = 1'b0;
        #1;
        n_checks++;
        if (m_axi_rready !== 1'b0 || fifo_wr !== 1'b0 || done_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL %s init cycle: rready=%b wr=%b done=%b required 0 0 0", name, m_axi_rready, fifo_wr, done_pulse);
        end

        b = 0;
        c = 0;
        while (b < total && c < max_c) begin
            @(negedge clk);
            if (toggle) full = c[0];
            else full = (c >= hold_at && c < hold_at + hold_len) || ($urandom_range(99) < full_pct);
            vld = ($urandom_range(99) < vld_pct);
            on_boundary = ((b % BPM) == BPM - 1);
            rr = (b == bad_resp_beat) ? 2'b10 : 2'b00;
            rl = on_boundary ^ (b == bad_last_beat);
            start_pulse = (c == stray_at);
            if (c == stray_at) begin
                mb_w = w + 3;
                mb_h = h + 1;
            end
            m_axi_rvalid = vld; m_axi_rdata = exp_q[0]; m_axi_rresp = rr; m_axi_rlast = rl;
            fifo_full = full;
            #1;
            exp_acc = vld && !full;
            n_checks++;
            if (m_axi_rready !== !full) begin
                n_fail++;
                $display("FAIL %s rready c=%0d: got %b required %b", name, c, m_axi_rready, !full);
            end
            n_checks++;
            if (fifo_wr !== exp_acc) begin
                n_fail++;
                $display("FAIL %s fifo_wr c=%0d beat=%0d: got %b required %b", name, c, b, fifo_wr, exp_acc);
            end
            n_checks++;
            if (done_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL %s early done c=%0d beat=%0d: got %b required 0", name, c, b, done_pulse);
            end
            if (c == 0) begin
                n_checks++;
                if (err_resp !== 1'b0 || err_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s flags at job start: got %b%b required 00", name, err_resp, err_last);
                end
            end
            if (exp_acc) begin
                got = exp_q.pop_front();
                n_checks++;
                if (fifo_din !== got) begin
                    n_fail++;
                    $display("FAIL %s fifo_din beat=%0d: got %h required %h", name, b, fifo_din, got);
                end
                exp_er = exp_er | (rr != 2'b00);
                exp_el = exp_el | (rl != on_boundary);
                b++;
            end
            c++;
        end
        start_pulse = 1'b0;
        if (b < total) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: %0d of %0d beats", name, b, total);
        end

        // Keep rvalid high after the job: no further beats may be taken
        @(negedge clk);
        m_axi_rvalid = 1'b1; fifo_full = 1'b0; m_axi_rdata = rand_data(); m_axi_rresp = 2'b00;
        #1;
        n_checks++;
        if (done_pulse !== 1'b1 || m_axi_rready !== 1'b0 || fifo_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done cycle: done=%b rready=%b wr=%b required 1 0 0", name, done_pulse, m_axi_rready, fifo_wr);
        end
        n_checks++;
        if (err_resp !== exp_er || err_last !== exp_el) begin
            n_fail++;
            $display("FAIL %s error flags: got resp=%b last=%b required resp=%b last=%b", name, err_resp, err_last, exp_er, exp_el);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (done_pulse !== 1'b0 || m_axi_rready !== 1'b0 || fifo_wr !== 1'b0) begin
                n_fail++;
                $display("FAIL %s after done %0d: done=%b rready=%b wr=%b required 0 0 0", name, k, done_pulse, m_axi_rready, fifo_wr);
            end
        end
        m_axi_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        m_axi_rvalid = 1'b1;
        start_pulse  = 1'b1;
        #1;
        n_checks++;
        if (m_axi_rready !== 1'b0 || fifo_wr !== 1'b0 || done_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outputs: rready=%b wr=%b done=%b required 0 0 0", m_axi_rready, fifo_wr, done_pulse);
        end
        n_checks++;
        if (err_resp !== 1'b0 || err_last !== 1'b0 || o_dbg_state !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset state: errs=%b%b state=%b required 00 0001", err_resp, err_last, o_dbg_state);
        end
        repeat (3) @(negedge clk);
        start_pulse  = 1'b0;
        m_axi_rvalid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_job(2, 1, 0, 100, -1, 0, 1'b0, -1, -1, -1, "basic");
    endtask

    task automatic test_fifo_stall();
        run_job(2, 1, 0, 100, 4, 4, 1'b0, -1, -1, -1, "stall");
    endtask

    task automatic test_zero_job();
        run_job(0, 5, 0, 100, -1, 0, 1'b0, -1, -1, -1, "zero");
    endtask

    task automatic test_errors();
        run_job(2, 1, 0, 100, -1, 0, 1'b0, 1, 2, -1, "errors");
        run_job(1, 1, 0, 100, -1, 0, 1'b0, -1, -1, -1, "errors_cleared");
    endtask

    task automatic test_reset_mid_job();
        @(negedge clk);
        start_pulse = 1'b1; mb_w = 2; mb_h = 1; fifo_full = 1'b0;
        @(negedge clk);
        start_pulse = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_axi_rvalid = 1'b1; m_axi_rdata = rand_data(); m_axi_rresp = 2'b00;
            m_axi_rlast = (k == BPM - 1);
            #1;
            n_checks++;
            if (fifo_wr !== 1'b1) begin
                n_fail++;
                $display("FAIL midreset beat %0d: wr=%b required 1", k, fifo_wr);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_axi_rready !== 1'b0 || fifo_wr !== 1'b0 || done_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset in reset: rready=%b wr=%b done=%b required 0 0 0", m_axi_rready, fifo_wr, done_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (m_axi_rready !== 1'b0 || fifo_wr !== 1'b0 || done_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL midreset idle %0d: rready=%b wr=%b done=%b required 0 0 0", k, m_axi_rready, fifo_wr, done_pulse);
            end
        end
        m_axi_rvalid = 1'b0;
        run_job(1, 1, 0, 100, -1, 0, 1'b0, -1, -1, -1, "after_reset");
    endtask

    task automatic test_fifo_toggle();
        run_job(3, 2, 0, 100, -1, 0, 1'b1, -1, -1, -1, "toggle");
    endtask

    task automatic test_stray_start();
        run_job(2, 2, 0, 100, -1, 0, 1'b0, -1, -1, 3, "stray_start");
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(3, 1), $urandom_range(2, 1), 30, 70, -1, 0, 1'b0,
                    int'($urandom_range(5)) - 1, int'($urandom_range(5)) - 1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fifo_stall();
        test_zero_job();
        test_errors();
        test_reset_mid_job();
        test_fifo_toggle();
        test_stray_start();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
